batch_line_reader: RTL and testbench



---
 rtl/batch_line_reader_if.sv | 31 +++
 rtl/batch_line_reader.sv | 145 ++++++++++++++
 tb/tb_batch_line_reader.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/batch_line_reader_if.sv
// Signal bundle between a batch_line_reader and its line RAM, row control and pixel consumer.
interface batch_line_reader_if #(
  parameter int unsigned BATCH_SIZE  = 16,
  parameter int unsigned BLOCK_DEPTH = 480,
  parameter int unsigned MAX_WIDTH   = 1920
);
  localparam int unsigned WW = $clog2(MAX_WIDTH);
  localparam int unsigned AW = $clog2(BLOCK_DEPTH);

  logic                    I_row_ready;
  logic [WW-1:0]           I_row_width;
  logic                    O_rd_en;
  logic [AW-1:0]           O_rd_addr;
  logic [8*BATCH_SIZE-1:0] I_rd_data;
  logic [7:0]              O_pixel;
  logic                    O_pixel_valid;
  logic                    I_pixel_ready;
  logic                    O_pixel_last;
  logic                    O_busy;
  logic                    O_overrun;

  modport master (
    input  I_row_ready, I_row_width, I_rd_data, I_pixel_ready,
    output O_rd_en, O_rd_addr, O_pixel, O_pixel_valid, O_pixel_last, O_busy, O_overrun
  );

  modport slave (
    output I_row_ready, I_row_width, I_rd_data, I_pixel_ready,
    input  O_rd_en, O_rd_addr, O_pixel, O_pixel_valid, O_pixel_last, O_busy, O_overrun
  );
endinterface

// File: rtl/batch_line_reader.sv
// Reads one completed row of batch words from line RAM and unpacks it into a
// byte-wide valid/ready pixel stream, prefetching one word ahead.
module batch_line_reader #(
  parameter int unsigned BATCH_SIZE  = 16,
  parameter int unsigned BLOCK_DEPTH = 480,
  parameter int unsigned MAX_WIDTH   = 1920
) (
  input  logic                I_clk,
  input  logic                I_rst_n,
  batch_line_reader_if.master bus
);
  localparam int unsigned WW  = $clog2(MAX_WIDTH);
  localparam int unsigned AW  = $clog2(BLOCK_DEPTH);
  localparam int unsigned PCW = WW + 1;
  localparam int unsigned DW  = 8 * BATCH_SIZE;
  localparam int unsigned BIW = $clog2(BATCH_SIZE);

  localparam logic [PCW-1:0] LP_MAXW      = PCW'(MAX_WIDTH);
  localparam logic [PCW-1:0] LP_BATCH     = PCW'(BATCH_SIZE);
  localparam logic [PCW-1:0] LP_BM1       = PCW'(BATCH_SIZE - 1);
  localparam logic [BIW-1:0] LP_LAST_BYTE = BIW'(BATCH_SIZE - 1);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_WAIT, S_STREAM} state_t;
  state_t r_state, w_next_state;

  logic [PCW-1:0] r_width, r_nwords, r_pix_cnt, r_next_addr;
  logic [BIW-1:0] r_byte_idx;
  logic [DW-1:0]  r_shift, r_pref;
  logic           r_pref_valid, r_rd_pend;
  logic           r_rd_en, r_valid, r_last, r_busy, r_overrun;
  logic [AW-1:0]  r_rd_addr;

  logic [PCW-1:0] w_req_raw, w_req_width, w_req_nwords;
  logic           w_start, w_xfer, w_final, w_word_end, w_issue;
  logic [DW-1:0]  w_next_word;

  assign w_req_raw    = {1'b0, bus.I_row_width};
  assign w_req_width  = (w_req_raw > LP_MAXW) ? LP_MAXW : w_req_raw;
  assign w_req_nwords = (w_req_width + LP_BM1) / LP_BATCH;

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) r_state <= S_IDLE;
    else          r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:   if (w_start) w_next_state = S_FETCH;
      S_FETCH:  w_next_state = S_WAIT;
      S_WAIT:   w_next_state = S_STREAM;
      S_STREAM: if (w_final) w_next_state = S_IDLE;
      default:  w_next_state = S_IDLE;
    endcase
  end

  // A word read one cycle ago is still on the RAM bus; take it directly so
  // the word boundary never stalls, even with two-pixel words.
  always_comb begin
    w_start     = (r_state == S_IDLE) && bus.I_row_ready && (w_req_width != '0);
    w_xfer      = (r_state == S_STREAM) && r_valid && bus.I_pixel_ready;
    w_final     = w_xfer && (r_pix_cnt == r_width - PCW'(1));
    w_word_end  = w_xfer && !w_final && (r_byte_idx == LP_LAST_BYTE);
    w_issue     = ((r_state == S_WAIT) || w_word_end) && (r_next_addr < r_nwords);
    w_next_word = r_pref_valid ? r_pref : bus.I_rd_data;
  end

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      r_width      <= '0;
      r_nwords     <= '0;
      r_pix_cnt    <= '0;
      r_next_addr  <= '0;
      r_byte_idx   <= '0;
      r_shift      <= '0;
      r_pref       <= '0;
      r_pref_valid <= 1'b0;
      r_rd_pend    <= 1'b0;
      r_rd_en      <= 1'b0;
      r_rd_addr    <= '0;
      r_valid      <= 1'b0;
      r_last       <= 1'b0;
      r_busy       <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_rd_en   <= 1'b0;
      r_rd_pend <= r_rd_en;
      r_overrun <= bus.I_row_ready && r_busy;
      if (r_rd_pend && (r_state == S_STREAM)) begin
        r_pref       <= bus.I_rd_data;
        r_pref_valid <= 1'b1;
      end
      case (r_state)
        S_IDLE: if (w_start) begin
          r_width      <= w_req_width;
          r_nwords     <= w_req_nwords;
          r_pix_cnt    <= '0;
          r_next_addr  <= PCW'(1);
          r_pref_valid <= 1'b0;
          r_busy       <= 1'b1;
          r_rd_en      <= 1'b1;
          r_rd_addr    <= '0;
        end
        S_WAIT: begin
          r_shift    <= bus.I_rd_data;
          r_byte_idx <= '0;
          r_valid    <= 1'b1;
          r_last     <= (r_width == PCW'(1));
        end
        S_STREAM: begin
          if (w_final) begin
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_busy  <= 1'b0;
          end else if (w_xfer) begin
            r_pix_cnt <= r_pix_cnt + PCW'(1);
            r_last    <= (r_pix_cnt + PCW'(2) == r_width);
            if (w_word_end) begin
              r_shift      <= w_next_word;
              r_byte_idx   <= '0;
              r_pref_valid <= 1'b0;
            end else begin
              r_shift    <= r_shift >> 8;
              r_byte_idx <= r_byte_idx + BIW'(1);
            end
          end
        end
        default: ;
      endcase
      if (w_issue) begin
        r_rd_en     <= 1'b1;
        r_rd_addr   <= AW'(r_next_addr);
        r_next_addr <= r_next_addr + PCW'(1);
      end
    end
  end

  assign bus.O_rd_en       = r_rd_en;
  assign bus.O_rd_addr     = r_rd_addr;
  assign bus.O_pixel       = r_shift[7:0];
  assign bus.O_pixel_valid = r_valid;
  assign bus.O_pixel_last  = r_last;
  assign bus.O_busy        = r_busy;
  assign bus.O_overrun     = r_overrun;
endmodule

// File: tb/tb_batch_line_reader.sv
// Directed bench for batch_line_reader: RAM model, expected-pixel queue, per-cycle monitor.
module tb_batch_line_reader;
  localparam int unsigned BS = 16;
  localparam int unsigned BD = 480;
  localparam int unsigned MW = 1920;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  batch_line_reader_if #(.BATCH_SIZE(BS), .BLOCK_DEPTH(BD), .MAX_WIDTH(MW)) bus();

  batch_line_reader #(.BATCH_SIZE(BS), .BLOCK_DEPTH(BD), .MAX_WIDTH(MW)) dut (
    .I_clk   (clk),
    .I_rst_n (rst_n),
    .bus     (bus)
  );

  logic [8*BS-1:0] mem [0:BD-1];
  always @(posedge clk) if (bus.O_rd_en) bus.I_rd_data <= mem[bus.O_rd_addr];

  int tests = 0;
  int fails = 0;
  logic [8:0] sb[$];
  int reads = 0, rd_next = 0, cur_n = 0, busy_cyc = 0, ovr_cnt = 0, pops = 0;
  logic hold_prev = 1'b0;
  logic [7:0] prev_pix = '0;
  logic prev_last = 1'b0;
  logic toggle = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic monitor();
    logic [8:0] e;
    if (!rst_n) begin
      hold_prev = 1'b0;
    end else begin
      if (bus.O_rd_en) begin
        reads++;
        check("rd_addr_order", 32'(bus.O_rd_addr), rd_next);
        check("rd_addr_in_range", 32'(int'(bus.O_rd_addr) < cur_n), 32'd1);
        rd_next++;
      end
      if (hold_prev)
        check("hold_stable", 32'({bus.O_pixel_valid, bus.O_pixel_last, bus.O_pixel}),
              32'({1'b1, prev_last, prev_pix}));
      if (bus.O_pixel_valid && bus.I_pixel_ready) begin
        check("pixel_expected", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          pops++;
          check("pixel_last_value", 32'({bus.O_pixel_last, bus.O_pixel}), 32'(e));
        end
      end
      if (bus.O_busy) busy_cyc++;
      if (bus.O_overrun) ovr_cnt++;
      hold_prev = bus.O_pixel_valid && !bus.I_pixel_ready;
      prev_pix  = bus.O_pixel;
      prev_last = bus.O_pixel_last;
    end
  endtask

  task automatic step();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
    if (toggle) bus.I_pixel_ready = ~bus.I_pixel_ready;
  endtask

  task automatic start_row(input int w);
    int eff;
    eff = (w > int'(MW)) ? int'(MW) : w;
    bus.I_row_width = 11'(w);
    bus.I_row_ready = 1'b1;
    rd_next = 0;
    cur_n = (eff + int'(BS) - 1) / int'(BS);
    for (int i = 0; i < eff; i++) sb.push_back({i == eff - 1, 8'(i)});
    step();
    bus.I_row_ready = 1'b0;
    if (eff > 0) begin
      check("c1_rd_en_addr0", 32'({bus.O_rd_en, bus.O_rd_addr}), 32'({1'b1, 9'd0}));
      step();
      check("c2_no_valid", 32'(bus.O_pixel_valid), 32'd0);
      step();
      check("c3_first_valid", 32'({bus.O_pixel_valid, bus.O_pixel}), 32'({1'b1, 8'h00}));
    end
  endtask

  task automatic run_done(input string tag, input int budget);
    int n = 0;
    while ((sb.size() != 0 || bus.O_busy) && n < budget) begin
      step();
      n++;
    end
    check({tag, "_complete"}, 32'(sb.size() == 0 && !bus.O_busy && !bus.O_pixel_valid), 32'd1);
    repeat (3) step();
  endtask

  initial begin
    int r0, b0, o0, p0, n;
    for (int w = 0; w < int'(BD); w++)
      for (int j = 0; j < int'(BS); j++) mem[w][8*j +: 8] = 8'(w * int'(BS) + j);
    bus.I_row_ready   = 1'b0;
    bus.I_row_width   = '0;
    bus.I_pixel_ready = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", 32'({bus.O_rd_en, bus.O_rd_addr, bus.O_pixel, bus.O_pixel_valid,
                                bus.O_pixel_last, bus.O_busy, bus.O_overrun}), 32'd0);
    rst_n = 1'b1;
    step();

    // width 32, ready high: gapless, 2 reads, busy cycles 1..34
    r0 = reads; b0 = busy_cyc;
    start_row(32);
    run_done("w32", 200);
    check("w32_reads", reads - r0, 2);
    check("w32_busy_cycles", busy_cyc - b0, 34);

    // width 20: partial last word
    r0 = reads; b0 = busy_cyc;
    start_row(20);
    run_done("w20", 200);
    check("w20_reads", reads - r0, 2);
    check("w20_busy_cycles", busy_cyc - b0, 22);

    // width 48 under alternating ready
    r0 = reads;
    toggle = 1'b1;
    start_row(48);
    run_done("w48_toggle", 400);
    toggle = 1'b0;
    bus.I_pixel_ready = 1'b1;
    check("w48_reads", reads - r0, 3);

    // second request while busy
    r0 = reads; o0 = ovr_cnt;
    start_row(32);
    step(); step();
    bus.I_row_width = 11'd32;
    bus.I_row_ready = 1'b1;
    step();
    bus.I_row_ready = 1'b0;
    check("ovr_pulse", 32'(bus.O_overrun), 32'd1);
    step();
    check("ovr_one_cycle", 32'(bus.O_overrun), 32'd0);
    run_done("ovr_row", 200);
    check("ovr_reads", reads - r0, 2);
    check("ovr_count", ovr_cnt - o0, 1);

    // width 0 is ignored
    r0 = reads; b0 = busy_cyc; o0 = ovr_cnt;
    start_row(0);
    repeat (6) step();
    check("w0_no_reads", reads - r0, 0);
    check("w0_not_busy", busy_cyc - b0, 0);
    check("w0_no_overrun", ovr_cnt - o0, 0);
    check("w0_no_valid", 32'(bus.O_pixel_valid), 32'd0);

    // oversize width clamps to the maximum row
    r0 = reads;
    start_row(2047);
    run_done("clamp", 4000);
    check("clamp_reads", reads - r0, 120);

    // reset mid-row, then a fresh short row
    p0 = pops; n = 0;
    start_row(64);
    while (pops - p0 < 10 && n < 100) begin
      step();
      n++;
    end
    check("rst_ten_pixels", pops - p0, 10);
    rst_n = 1'b0;
    #1;
    check("rst_mid_outputs", 32'({bus.O_rd_en, bus.O_rd_addr, bus.O_pixel, bus.O_pixel_valid,
                                  bus.O_pixel_last, bus.O_busy, bus.O_overrun}), 32'd0);
    sb.delete();
    hold_prev = 1'b0;
    step(); step();
    rst_n = 1'b1;
    step();
    r0 = reads;
    start_row(16);
    run_done("post_rst_w16", 200);
    check("post_rst_reads", reads - r0, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
